// File: rtl/iob_spi_fl_linebuf_pkg.sv
// rtl/iob_spi_fl_linebuf_pkg.sv - shared types and sizing helpers for the flash read line buffer
package iob_spi_fl_linebuf_pkg;

    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_LINE_LOG2 = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WBUSY  = 3'd2,
        WDONE  = 3'd3,
        RESP_H = 3'd4,
        RESP_W = 3'd5
    } state_t;

    function automatic int line_words(input int line_log2);
        return 1 << line_log2;
    endfunction

    function automatic int tag_width(input int addr_w, input int line_log2);
        return addr_w - line_log2 - 2;
    endfunction

    localparam int LINE_WORDS = line_words(DEF_LINE_LOG2);
    localparam int TAG_W      = tag_width(DEF_ADDR_W, DEF_LINE_LOG2);

endpackage

// File: rtl/iob_spi_fl_linebuf_mem.sv
// rtl/iob_spi_fl_linebuf_mem.sv - line storage: one write port, asynchronous read port
module iob_spi_fl_linebuf_mem #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/iob_spi_fl_linebuf.sv
// rtl/iob_spi_fl_linebuf.sv - single-line read buffer in front of the SPI flash controller cache port
module iob_spi_fl_linebuf
    import iob_spi_fl_linebuf_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LINE_LOG2 = DEF_LINE_LOG2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_cache_i,
    input  logic [ADDR_W-1:0]   address_cache_i,
    input  logic [DATA_W/8-1:0] wstrb_cache_i,
    output logic [DATA_W-1:0]   rdata_cache_o,
    output logic                ready_cache_o,
    input  logic                invalidate_i,
    output logic                wr_err_o,
    output logic                fl_valid_o,
    output logic [31:0]         fl_address_o,
    input  logic [DATA_W-1:0]   fl_data_i,
    input  logic                fl_ready_i
);

    localparam int NWORDS = line_words(LINE_LOG2);
    localparam int TW     = tag_width(ADDR_W, LINE_LOG2);
    localparam int CNT_W  = (LINE_LOG2 > 0) ? LINE_LOG2 : 1;

    state_t            state;
    logic [TW-1:0]     tag;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  req_idx;
    logic              line_vld;
    logic              inv_pend;

    logic [TW-1:0]     req_tag;
    logic [CNT_W-1:0]  req_word;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] base_req;
    logic [ADDR_W-1:0] base_cur;
    logic              is_write;
    logic              hit;
    logic              in_refill;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_tag   = address_cache_i[ADDR_W-1:LINE_LOG2+2];
    assign req_word  = CNT_W'((address_cache_i >> 2) & ADDR_W'(NWORDS - 1));
    assign cnt_nxt   = cnt + 1'b1;
    assign base_req  = {req_tag, {(LINE_LOG2+2){1'b0}}};
    assign base_cur  = {tag, {(LINE_LOG2+2){1'b0}}};
    assign is_write  = |wstrb_cache_i;
    assign hit       = line_vld && (tag == req_tag);
    assign in_refill = (state == ISSUE) || (state == WBUSY) || (state == WDONE);
    assign mem_we    = (state == WDONE) && fl_ready_i;

    iob_spi_fl_linebuf_mem #(
        .DATA_W (DATA_W),
        .WORDS  (NWORDS),
        .IDX_W  (CNT_W)
    ) u_mem (
        .clk_i  (clk_i),
        .we     (mem_we),
        .widx   (cnt),
        .wdata  (fl_data_i),
        .ridx   (req_idx),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            tag           <= '0;
            cnt           <= '0;
            req_idx       <= '0;
            line_vld      <= 1'b0;
            inv_pend      <= 1'b0;
            rdata_cache_o <= '0;
            ready_cache_o <= 1'b0;
            wr_err_o      <= 1'b0;
            fl_valid_o    <= 1'b0;
            fl_address_o  <= '0;
        end else begin
            ready_cache_o <= 1'b0;
            rdata_cache_o <= '0;
            fl_valid_o    <= 1'b0;

            // A refill in flight is never aborted; the drop is deferred until the response.
            if (invalidate_i) begin
                if (in_refill) begin
                    inv_pend <= 1'b1;
                end else begin
                    line_vld <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    // ready_cache_o high means the requester has not yet dropped valid.
                    if (valid_cache_i && !ready_cache_o) begin
                        req_idx <= req_word;
                        if (is_write) begin
                            state <= RESP_W;
                        end else if (hit) begin
                            state <= RESP_H;
                        end else begin
                            tag          <= req_tag;
                            cnt          <= '0;
                            line_vld     <= 1'b0;
                            fl_address_o <= 32'(base_req);
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (fl_ready_i) begin
                        fl_valid_o <= 1'b1;
                        state      <= WBUSY;
                    end
                end
                WBUSY: begin
                    if (!fl_ready_i) begin
                        state <= WDONE;
                    end
                end
                WDONE: begin
                    if (fl_ready_i) begin
                        if (cnt == CNT_W'(NWORDS - 1)) begin
                            line_vld <= 1'b1;
                            state    <= RESP_H;
                        end else begin
                            cnt          <= cnt_nxt;
                            fl_address_o <= 32'(base_cur | (ADDR_W'(cnt_nxt) << 2));
                            state        <= ISSUE;
                        end
                    end
                end
                RESP_H: begin
                    ready_cache_o <= 1'b1;
                    rdata_cache_o <= mem_rdata;
                    if (inv_pend) begin
                        line_vld <= 1'b0;
                        inv_pend <= 1'b0;
                    end
                    state <= IDLE;
                end
                RESP_W: begin
                    ready_cache_o <= 1'b1;
                    wr_err_o      <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_spi_fl_linebuf.sv
// tb/tb_iob_spi_fl_linebuf.sv - scoreboard bench for the flash read line buffer
module tb_iob_spi_fl_linebuf;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_cache_i = 1'b0;
    logic [23:0] address_cache_i = '0;
    logic [3:0]  wstrb_cache_i = '0;
    logic [31:0] rdata_cache_o;
    logic        ready_cache_o;
    logic        invalidate_i = 1'b0;
    logic        wr_err_o;
    logic        fl_valid_o;
    logic [31:0] fl_address_o;
    logic [31:0] fl_data_i;
    logic        fl_ready_i;

    always #5 clk_i = ~clk_i;

    iob_spi_fl_linebuf dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_cache_i   (valid_cache_i),
        .address_cache_i (address_cache_i),
        .wstrb_cache_i   (wstrb_cache_i),
        .rdata_cache_o   (rdata_cache_o),
        .ready_cache_o   (ready_cache_o),
        .invalidate_i    (invalidate_i),
        .wr_err_o        (wr_err_o),
        .fl_valid_o      (fl_valid_o),
        .fl_address_o    (fl_address_o),
        .fl_data_i       (fl_data_i),
        .fl_ready_i      (fl_ready_i)
    );

    int          tests = 0;
    int          fails = 0;
    int          fl_pulses = 0;
    logic [31:0] exp_rd_q [$];
    logic [31:0] exp_fa_q [$];

    // Controller model: busy 20 cycles after each start, returns ~address.
    int busy;
    always @(posedge clk_i) begin
        if (rst_i) begin
            fl_ready_i <= 1'b1;
            fl_data_i  <= '0;
            busy       <= 0;
        end else if (fl_valid_o) begin
            fl_ready_i <= 1'b0;
            fl_data_i  <= ~fl_address_o;
            busy       <= 20;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) fl_ready_i <= 1'b1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    always @(negedge clk_i) begin
        if (fl_valid_o) begin
            fl_pulses++;
            if (!fl_ready_i) begin
                fails++;
                $display("FAIL fl_valid_while_busy: got fl_ready_i=0 expected 1");
            end
            if (prev_v) begin
                fails++;
                $display("FAIL fl_valid_back_to_back: got 2 consecutive expected 1");
            end
            if (exp_fa_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fl_address_unexpected: got 0x%08h expected no start", fl_address_o);
            end else begin
                check32("fl_address", fl_address_o, exp_fa_q.pop_front());
            end
        end
        if (ready_cache_o) begin
            if (prev_r) begin
                fails++;
                $display("FAIL ready_back_to_back: got 2 consecutive expected 1");
            end
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ready_unexpected: got rdata 0x%08h expected no response", rdata_cache_o);
            end else begin
                check32("rdata", rdata_cache_o, exp_rd_q.pop_front());
            end
        end
        prev_v = fl_valid_o;
        prev_r = ready_cache_o;
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_fa_q.push_back(base + 32'(i * 4));
    endtask

    task automatic do_req(input logic [23:0] a, input logic [3:0] ws, output int lat, output int pulses);
        int p0;
        p0 = fl_pulses;
        address_cache_i = a;
        wstrb_cache_i   = ws;
        valid_cache_i   = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clk_i);
            lat++;
            #1;
            if (ready_cache_o) break;
            if (lat >= 600) begin
                tests++;
                fails++;
                $display("FAIL req_timeout: got no ready after %0d cycles expected ready", lat);
                break;
            end
        end
        valid_cache_i = 1'b0;
        wstrb_cache_i = '0;
        @(negedge clk_i);
        pulses = fl_pulses - p0;
        @(posedge clk_i);
        #1;
    endtask

    int lat, pl, p_base, w;

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check32("reset_ready", 32'(ready_cache_o), 0);
        check32("reset_rdata", rdata_cache_o, 0);
        check32("reset_fl_valid", 32'(fl_valid_o), 0);
        check32("reset_fl_address", fl_address_o, 0);
        check32("reset_wr_err", 32'(wr_err_o), 0);
        @(posedge clk_i);
        #1;

        // 1 cold read
        push_line(32'h100);
        exp_rd_q.push_back(32'hFFFFFEFB);
        do_req(24'h000104, 4'h0, lat, pl);
        check32("t1_pulses", 32'(pl), 4);

        // 2 hit
        exp_rd_q.push_back(32'hFFFFFEF3);
        do_req(24'h00010C, 4'h0, lat, pl);
        check32("t2_latency", 32'(lat), 2);
        check32("t2_pulses", 32'(pl), 0);

        // 3 line replacement
        push_line(32'h200);
        exp_rd_q.push_back(32'hFFFFFDFF);
        do_req(24'h000200, 4'h0, lat, pl);
        check32("t3_pulses", 32'(pl), 4);
        push_line(32'h100);
        exp_rd_q.push_back(32'hFFFFFEFF);
        do_req(24'h000100, 4'h0, lat, pl);
        check32("t3_remiss_pulses", 32'(pl), 4);

        // 4 write request
        exp_rd_q.push_back(32'h0);
        do_req(24'h000100, 4'hF, lat, pl);
        check32("t4_latency", 32'(lat), 2);
        check32("t4_pulses", 32'(pl), 0);
        check32("t4_wr_err", 32'(wr_err_o), 1);
        exp_rd_q.push_back(32'hFFFFFEFB);
        do_req(24'h000104, 4'h0, lat, pl);
        check32("t4_hit_pulses", 32'(pl), 0);
        check32("t4_wr_err_sticky", 32'(wr_err_o), 1);

        // 5 invalidate during the second word of a refill
        push_line(32'h300);
        exp_rd_q.push_back(32'hFFFFFCF7);
        p_base = fl_pulses;
        fork
            do_req(24'h000308, 4'h0, lat, pl);
            begin
                w = 0;
                while (fl_pulses < p_base + 2 && w < 600) begin
                    @(posedge clk_i);
                    w++;
                end
                #1 invalidate_i = 1'b1;
                @(posedge clk_i);
                #1 invalidate_i = 1'b0;
            end
        join
        check32("t5_pulses", 32'(pl), 4);
        push_line(32'h300);
        exp_rd_q.push_back(32'hFFFFFCFB);
        do_req(24'h000304, 4'h0, lat, pl);
        check32("t5_remiss_pulses", 32'(pl), 4);

        // 6 reset in WDONE
        exp_fa_q.push_back(32'h400);
        p_base = fl_pulses;
        address_cache_i = 24'h000400;
        valid_cache_i = 1'b1;
        w = 0;
        while (fl_pulses == p_base && w < 600) begin
            @(posedge clk_i);
            w++;
        end
        check32("t6_first_pulse_seen", 32'(fl_pulses - p_base), 1);
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        valid_cache_i = 1'b0;
        @(posedge clk_i);
        #1;
        check32("t6_ready", 32'(ready_cache_o), 0);
        check32("t6_rdata", rdata_cache_o, 0);
        check32("t6_fl_valid", 32'(fl_valid_o), 0);
        check32("t6_fl_address", fl_address_o, 0);
        check32("t6_wr_err", 32'(wr_err_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        push_line(32'h300);
        exp_rd_q.push_back(32'hFFFFFCF3);
        do_req(24'h00030C, 4'h0, lat, pl);
        check32("t6_remiss_pulses", 32'(pl), 4);

        repeat (5) @(posedge clk_i);
        check32("rd_queue_empty", 32'(exp_rd_q.size()), 0);
        check32("fa_queue_empty", 32'(exp_fa_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
